// File: rtl/adder8_reg_if.sv
// Handshake bundle for adder8_reg: operand input channel and registered result channel.
// master = producer/consumer side, slave = the adder.
interface adder8_reg_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, sum, carry, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, sum, carry, ovf, zero
    );
endinterface

// File: rtl/adder8_reg.sv
// Registered adder with a single-entry valid/ready output stage and carry/ovf/zero flags.
// Optional macro ADDER8_REG_SAT_EN: unsigned saturation on carry instead of modulo wrap.
module adder8_reg #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    adder8_reg_if.slave bus
);
    logic [WIDTH:0]   w_full;
    logic [WIDTH-1:0] w_sum;
    logic             w_carry;
    logic             w_ovf;
    logic             w_zero;
    logic             w_accept;
    logic             w_consume;
    logic             w_in_ready;

    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_ovf;
    logic             r_zero;
    logic             r_valid;

    assign w_full  = {1'b0, bus.a} + {1'b0, bus.b};
    assign w_carry = w_full[WIDTH];
    // Signed overflow judged on the true modulo sum, so saturation leaves it untouched.
    assign w_ovf   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                     (w_full[WIDTH-1] != bus.a[WIDTH-1]);

`ifdef ADDER8_REG_SAT_EN
    assign w_sum = w_carry ? {WIDTH{1'b1}} : w_full[WIDTH-1:0];
`else
    assign w_sum = w_full[WIDTH-1:0];
`endif

    assign w_zero     = (w_sum == '0);
    assign w_in_ready = !r_valid || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_consume  = r_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_valid <= 1'b1;
                r_sum   <= w_sum;
                r_carry <= w_carry;
                r_ovf   <= w_ovf;
                r_zero  <= w_zero;
            end else if (w_consume) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_valid;
    assign bus.sum       = r_sum;
    assign bus.carry     = r_carry;
    assign bus.ovf       = r_ovf;
    assign bus.zero      = r_zero;
endmodule

// File: tb/tb_adder8_reg.sv
// Directed self-checking bench for adder8_reg: reset, vectors, wrap/saturation, backpressure.
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_adder8_reg;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    adder8_reg_if #(.WIDTH(8)) bus_i ();

    adder8_reg #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_i.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one operand pair at a falling edge, let it be accepted, check the result one cycle on.
    task automatic vec(input string tag, input logic [7:0] va, input logic [7:0] vb,
                       input logic [7:0] es, input logic ec, input logic eo, input logic ez);
        bus_i.in_valid = 1'b1;
        bus_i.a        = va;
        bus_i.b        = vb;
        #1 chk({tag, "_in_ready"}, bus_i.in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_valid"}, bus_i.out_valid, 1);
        chk({tag, "_sum"},   bus_i.sum,       es);
        chk({tag, "_carry"}, bus_i.carry,     ec);
        chk({tag, "_ovf"},   bus_i.ovf,       eo);
        chk({tag, "_zero"},  bus_i.zero,      ez);
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        rst_n           = 1'b0;
        bus_i.in_valid  = 1'b0;
        bus_i.a         = 8'd0;
        bus_i.b         = 8'd0;
        bus_i.out_ready = 1'b1;

        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", bus_i.out_valid, 0);
        chk("rst_sum",   bus_i.sum,       0);
        chk("rst_carry", bus_i.carry,     0);
        chk("rst_ovf",   bus_i.ovf,       0);
        chk("rst_zero",  bus_i.zero,      0);
        rst_n = 1'b1;
        #1 chk("post_rst_in_ready", bus_i.in_ready, 1);
        chk("post_rst_valid", bus_i.out_valid, 0);

        vec("v0_0",     8'd0,   8'd0,   8'd0,   1'b0, 1'b0, 1'b1);
        vec("v5_10",    8'd5,   8'd10,  8'd15,  1'b0, 1'b0, 1'b0);
        vec("v50_25",   8'd50,  8'd25,  8'd75,  1'b0, 1'b0, 1'b0);
        vec("v100_155", 8'd100, 8'd155, 8'd255, 1'b0, 1'b0, 1'b0);
`ifdef ADDER8_REG_SAT_EN
        vec("v128_128", 8'd128, 8'd128, 8'd255, 1'b1, 1'b1, 1'b0);
        vec("v255_1",   8'd255, 8'd1,   8'd255, 1'b1, 1'b0, 1'b0);
        vec("v127_1",   8'd127, 8'd1,   8'd128, 1'b0, 1'b1, 1'b0);
        vec("v255_255", 8'd255, 8'd255, 8'd255, 1'b1, 1'b0, 1'b0);
`else
        vec("v128_128", 8'd128, 8'd128, 8'd0,   1'b1, 1'b1, 1'b1);
        vec("v255_1",   8'd255, 8'd1,   8'd0,   1'b1, 1'b0, 1'b1);
        vec("v127_1",   8'd127, 8'd1,   8'd128, 1'b0, 1'b1, 1'b0);
        vec("v255_255", 8'd255, 8'd255, 8'd254, 1'b1, 1'b0, 1'b0);
`endif

        // Backpressure: hold 15, offer 50+25 while stalled
        vec("bp_first", 8'd5, 8'd10, 8'd15, 1'b0, 1'b0, 1'b0);
        bus_i.out_ready = 1'b0;
        bus_i.a         = 8'd50;
        bus_i.b         = 8'd25;
        #1 chk("bp_in_ready_low", bus_i.in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_stall_in_ready", bus_i.in_ready,  0);
            chk("bp_stall_valid",    bus_i.out_valid, 1);
            chk("bp_stall_sum",      bus_i.sum,       15);
        end
        bus_i.out_ready = 1'b1;
        #1 chk("bp_release_in_ready", bus_i.in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        chk("bp_next_valid", bus_i.out_valid, 1);
        chk("bp_next_sum",   bus_i.sum,       75);
        bus_i.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("drain_valid", bus_i.out_valid, 0);
        chk("drain_sum",   bus_i.sum,       75);
        chk("drain_in_ready", bus_i.in_ready, 1);

        // Reset mid-stream with a held result: clears without a clock edge
        bus_i.in_valid  = 1'b1;
        bus_i.a         = 8'd5;
        bus_i.b         = 8'd10;
        bus_i.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_valid_before", bus_i.out_valid, 1);
        chk("mid_sum_before",   bus_i.sum,       15);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", bus_i.out_valid, 0);
        chk("mid_rst_sum",   bus_i.sum,       0);
        bus_i.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("mid_post_in_ready", bus_i.in_ready, 1);
        chk("mid_post_valid", bus_i.out_valid, 0);
        @(posedge clk);
        @(negedge clk);
        chk("mid_idle_valid", bus_i.out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/adder8_reg.md
Name: adder8_reg

Overview:
- Registered unsigned adder with a valid/ready handshake on input and output.
- Sums two WIDTH-bit operands modulo 2^WIDTH and presents the result one cycle later, with carry, signed-overflow and zero flags.
- Used as the arithmetic leaf of datapath pipelines; one clock domain, asynchronous active-low reset.

Parameters:
- WIDTH, 8, operand and sum width in bits (WIDTH >= 2).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands a/b are valid this cycle.
- in_ready  output  1  block can accept operands this cycle.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- out_valid  output  1  sum and flags are valid.
- out_ready  input  1  downstream accepts the result this cycle.
- sum  output  WIDTH  (a + b) mod 2^WIDTH, registered.
- carry  output  1  bit WIDTH of the full a + b, i.e. unsigned overflow.
- ovf  output  1  two's-complement overflow: a and b have the same MSB, and the sum MSB differs.
- zero  output  1  sum == 0.

Behaviour:
Reset
- Reset is asynchronous, active-low, and takes effect immediately on rst_n low.
- While in reset: out_valid=0, sum=0, carry=0, ovf=0, zero=0.
- in_ready is 1 on the first cycle after reset deasserts.
- Reset asserted mid-operation discards any held result.

Handshake
- Single-entry output register.
- in_ready = !out_valid || out_ready. This is combinational; no dependence on in_valid.
- Input accepted on a rising edge when in_valid && in_ready. On that edge, sum, carry, ovf and zero load from a/b, and out_valid becomes 1.
- Output consumed on a rising edge when out_valid && out_ready.
- Consume with no accept: out_valid goes to 0; sum and flags hold their last values.
- Simultaneous accept and consume: the new result replaces the old one and out_valid stays 1. This gives full throughput of one operation per cycle.
- With out_valid=1 and out_ready=0: in_ready=0, and sum and flags hold stable.

Latency and arithmetic
- Latency: result visible exactly 1 cycle after the accepting edge.
- Internally a + b is computed at WIDTH+1 bits. sum = low WIDTH bits; carry = MSB.
- No combinational path from a/b to the outputs; every output except in_ready is registered.

Boundaries
- 0+0: sum=0, zero=1.
- Max+1 wraps: sum=0, carry=1, zero=1.
- in_valid while in_ready=0: the operands are ignored, and the upstream must hold them.

Optional Feature:
- Macro ADDER8_REG_SAT_EN.
- Defined: unsigned saturation. When carry=1, sum is forced to 2^WIDTH-1 and zero=0. carry still reports the true overflow, and ovf is unchanged.
- Undefined: modulo wrap as described above. Default build leaves the macro undefined.

Test Plan:
- Reset: hold rst_n=0 mid-stream with out_valid=1. Required: outputs clear immediately without waiting for a clock edge; after release, in_ready=1 and out_valid=0.
- Basic vectors, out_ready=1, one per cycle:
  - (0,0) -> sum=0, zero=1, carry=0.
  - (5,10) -> 15.
  - (50,25) -> 75.
  - (100,155) -> 255, carry=0, ovf=0.
  - Each appears 1 cycle after its accept.
- Wrap, default build:
  - (128,128) -> sum=0, carry=1, ovf=1, zero=1.
  - (255,1) -> sum=0, carry=1, ovf=0, zero=1.
- Saturation build (ADDER8_REG_SAT_EN defined):
  - (128,128) -> sum=255, carry=1, zero=0.
  - (255,1) -> sum=255.
- Backpressure: accept (5,10), then hold out_ready=0 for 3 cycles while driving in_valid=1 with (50,25).
  - During the stall: in_ready=0, sum stays 15, out_valid=1.
  - Raise out_ready: 15 is consumed, (50,25) is accepted on the same edge, and 75 appears next cycle.
- Signed overflow: (127,1) -> sum=128, ovf=1, carry=0. (255,255) -> sum=254, carry=1, ovf=0.
